useq_controller: RTL and testbench

USEQ_CONTROLLER -- requirements
Module: useq_controller

---
 rtl/useq_pkg.sv | 72 +++++++
 rtl/useq_decoder.sv | 52 +++++
 rtl/useq_controller.sv | 192 +++++++++++++++++++
 tb/tb_useq_controller.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/useq_pkg.sv
// Shared constants for the micro-sequencer: state codes, ALU codes,
// register numbers, opcode classes, op3 values and branch conditions.
// No logic lives here; the state codes double as the uSeq_State_Out values.
package useq_pkg;

   // Sequencer states (value driven on uSeq_State_Out)
   localparam logic [3:0] ST_IDLE     = 4'd0;
   localparam logic [3:0] ST_FETCH    = 4'd1;
   localparam logic [3:0] ST_DECODE   = 4'd2;
   localparam logic [3:0] ST_EXEC_ALU = 4'd3;
   localparam logic [3:0] ST_MEM      = 4'd4;
   localparam logic [3:0] ST_BRANCH   = 4'd5;
   localparam logic [3:0] ST_PC_INC   = 4'd6;
   localparam logic [3:0] ST_FAULT    = 4'd7;
   localparam logic [3:0] ST_TRAP     = 4'd8;

   // ALU operation codes
   localparam logic [3:0] ALU_ADD   = 4'h0;
   localparam logic [3:0] ALU_ADDCC = 4'h1;
   localparam logic [3:0] ALU_AND   = 4'h2;
   localparam logic [3:0] ALU_ANDCC = 4'h3;
   localparam logic [3:0] ALU_OR    = 4'h4;
   localparam logic [3:0] ALU_ORCC  = 4'h5;
   localparam logic [3:0] ALU_PASSA = 4'hC;
   localparam logic [3:0] ALU_INC4  = 4'hD;

   // Register-file numbers used in MIR fields
   localparam logic [5:0] REG_R0   = 6'd0;
   localparam logic [5:0] REG_PC   = 6'd32;
   localparam logic [5:0] REG_IR   = 6'd37;
   localparam logic [5:0] REG_SIMM = 6'd38;

   // Opcode class in IR_OP[7:6]
   localparam logic [1:0] CLS_BRANCH = 2'b00;
   localparam logic [1:0] CLS_CALL   = 2'b01;
   localparam logic [1:0] CLS_ALU    = 2'b10;
   localparam logic [1:0] CLS_MEM    = 2'b11;

   // op3 values in IR_OP[5:0]
   localparam logic [5:0] OP3_ADD   = 6'h00;
   localparam logic [5:0] OP3_AND   = 6'h01;
   localparam logic [5:0] OP3_OR    = 6'h02;
   localparam logic [5:0] OP3_ADDCC = 6'h10;
   localparam logic [5:0] OP3_ANDCC = 6'h11;
   localparam logic [5:0] OP3_ORCC  = 6'h12;
   localparam logic [5:0] OP3_LD    = 6'h00;
   localparam logic [5:0] OP3_ST    = 6'h04;

   // Branch condition in IR_OP[5:2]
   localparam logic [3:0] COND_BA   = 4'h8;
   localparam logic [3:0] COND_BE   = 4'h1;
   localparam logic [3:0] COND_BNEG = 4'h6;
   localparam logic [3:0] COND_BCS  = 4'h5;
   localparam logic [3:0] COND_BVS  = 4'h7;

   // PSR bit positions, register layout {N,Z,V,C}
   localparam int PSR_N = 3;
   localparam int PSR_Z = 2;
   localparam int PSR_V = 1;
   localparam int PSR_C = 0;

   // Opcode decode result
   typedef struct packed {
      logic [3:0] alu_code;
      logic       is_alu;     // class ALU with a supported op3
      logic       is_mem;     // ld or st
      logic       is_st;
      logic       is_branch;
      logic       taken;      // branch condition true against the given PSR
   } decode_t;

endpackage

// File: rtl/useq_decoder.sv
// Opcode decoder: op3 -> ALU code, opcode legality and branch-condition test.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: op = IR opcode {class, op3/cond}; psr = {N,Z,V,C}; dec = decode result.
module useq_decoder
   import useq_pkg::*;
(
   input  logic [7:0] op,
   input  logic [3:0] psr,
   output decode_t    dec
);

   logic [1:0] cls;
   logic [5:0] op3;
   logic [3:0] cond;
   logic       alu_ok;

   assign cls  = op[7:6];
   assign op3  = op[5:0];
   assign cond = op[5:2];

   always_comb begin
      dec          = '0;
      dec.alu_code = ALU_PASSA;
      alu_ok       = 1'b1;

      case (op3)
         OP3_ADD:   dec.alu_code = ALU_ADD;
         OP3_AND:   dec.alu_code = ALU_AND;
         OP3_OR:    dec.alu_code = ALU_OR;
         OP3_ADDCC: dec.alu_code = ALU_ADDCC;
         OP3_ANDCC: dec.alu_code = ALU_ANDCC;
         OP3_ORCC:  dec.alu_code = ALU_ORCC;
         default:   alu_ok       = 1'b0;
      endcase

      dec.is_alu    = (cls == CLS_ALU) && alu_ok;
      dec.is_mem    = (cls == CLS_MEM) && ((op3 == OP3_LD) || (op3 == OP3_ST));
      dec.is_st     = (cls == CLS_MEM) && (op3 == OP3_ST);
      dec.is_branch = (cls == CLS_BRANCH);

      // Unlisted conditions are treated as never taken
      case (cond)
         COND_BA:   dec.taken = 1'b1;
         COND_BE:   dec.taken = psr[PSR_Z];
         COND_BNEG: dec.taken = psr[PSR_N];
         COND_BCS:  dec.taken = psr[PSR_C];
         COND_BVS:  dec.taken = psr[PSR_V];
         default:   dec.taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/useq_controller.sv
// Micro-sequencer: fetch/decode/execute control for a SPARC-like datapath.
// Latency: one state per clock; FETCH and MEM wait for Mem_Ack up to MEM_TIMEOUT cycles, then FAULT.
// Backpressure: memory stalls via Mem_Ack only; no other input can stall the sequence.
// Ports: clock/async active-low reset, Start, IR opcode + IR13, active-low ALU flags,
//        flag-write request, memory ack in; ALU code, A/B/C MIR register numbers and
//        selectors, data-memory selector, Rd/Wr strobes, PSR, state code and halt out.
// Build option: define USEQ_TRAP_EN to stop in TRAP on an illegal opcode
//               (default: illegal opcode behaves as a NOP).
module useq_controller
   import useq_pkg::*;
#(
   parameter int DATAWIDTH_BUS_REG_IR_OP     = 8,
   parameter int DATAWIDTH_ALU_SELECTION     = 4,
   parameter int DATAWIDTH_BUS_REG_MIR_FIELD = 6,
   parameter int MEM_TIMEOUT                 = 15
)(
   input  logic                                   uSeq_CLOCK_50,
   input  logic                                   uSeq_RESET_InLow,
   input  logic                                   uSeq_Start_In,
   input  logic [DATAWIDTH_BUS_REG_IR_OP-1:0]     uSeq_Reg_IR_OP,
   input  logic                                   uSeq_Reg_IR_IR13,
   input  logic                                   uSeq_Overflow_InLow,
   input  logic                                   uSeq_Carry_InLow,
   input  logic                                   uSeq_Negative_InLow,
   input  logic                                   uSeq_Zero_InLow,
   input  logic                                   uSeq_ALU_Flags_Write_PCR,
   input  logic                                   uSeq_Mem_Ack_In,
   output logic [DATAWIDTH_ALU_SELECTION-1:0]     uSeq_ALU_Selection_Out,
   output logic [DATAWIDTH_BUS_REG_MIR_FIELD-1:0] uSeq_MUX_A_MIR,
   output logic [DATAWIDTH_BUS_REG_MIR_FIELD-1:0] uSeq_MUX_B_MIR,
   output logic [DATAWIDTH_BUS_REG_MIR_FIELD-1:0] uSeq_MUX_C_MIR,
   output logic                                   uSeq_MUX_A_MIR_Selector,
   output logic                                   uSeq_MUX_B_MIR_Selector,
   output logic                                   uSeq_MUX_C_MIR_Selector,
   output logic                                   uSeq_DataMemory_Selector_Out,
   output logic                                   uSeq_Mem_Rd_Out,
   output logic                                   uSeq_Mem_Wr_Out,
   output logic [3:0]                             uSeq_PSR_Flags_Out,
   output logic [3:0]                             uSeq_State_Out,
   output logic                                   uSeq_Halt_Out
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   logic [3:0]       state, state_nxt;
   logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
   logic [3:0]       psr;
   decode_t          dec;

   // Decode results captured in DECODE; PSR cannot change between DECODE and
   // BRANCH, so the branch outcome can be resolved at latch time.
   logic [3:0]       alu_q;
   logic             is_st_q;
   logic             taken_q;
   logic             ir13_q;

   useq_decoder u_decoder (
      .op  (uSeq_Reg_IR_OP),
      .psr (psr),
      .dec (dec)
   );

   // Next state and memory-wait counter. The counter returns to zero on every
   // exit from a wait state, so it is already clear when FETCH/MEM is entered.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = '0;
      case (state)
         ST_IDLE: begin
            if (uSeq_Start_In) state_nxt = ST_FETCH;
         end
         ST_FETCH, ST_MEM: begin
            // Ack in the final allowed cycle still counts as a normal exit
            if (uSeq_Mem_Ack_In)
               state_nxt = (state == ST_FETCH) ? ST_DECODE : ST_PC_INC;
            else if (wait_cnt == WAIT_LAST)
               state_nxt = ST_FAULT;
            else
               wait_cnt_nxt = wait_cnt + CNT_W'(1);
         end
         ST_DECODE: begin
            if (dec.is_alu)
               state_nxt = ST_EXEC_ALU;
            else if (dec.is_mem)
               state_nxt = ST_MEM;
            else if (dec.is_branch)
               state_nxt = ST_BRANCH;
            else begin
`ifdef USEQ_TRAP_EN
               state_nxt = ST_TRAP;
`else
               state_nxt = ST_PC_INC;
`endif
            end
         end
         ST_EXEC_ALU: state_nxt = ST_PC_INC;
         ST_BRANCH:   state_nxt = taken_q ? ST_FETCH : ST_PC_INC;
         ST_PC_INC:   state_nxt = ST_FETCH;
         ST_FAULT:    state_nxt = ST_FAULT;
         ST_TRAP:     state_nxt = ST_TRAP;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge uSeq_CLOCK_50 or negedge uSeq_RESET_InLow) begin
      if (!uSeq_RESET_InLow) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
         psr      <= 4'h0;
         alu_q    <= ALU_PASSA;
         is_st_q  <= 1'b0;
         taken_q  <= 1'b0;
         ir13_q   <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (state == ST_DECODE) begin
            alu_q   <= dec.alu_code;
            is_st_q <= dec.is_st;
            taken_q <= dec.taken;
            ir13_q  <= uSeq_Reg_IR_IR13;
         end
         if ((state == ST_EXEC_ALU) && uSeq_ALU_Flags_Write_PCR)
            psr <= ~{uSeq_Negative_InLow, uSeq_Zero_InLow,
                     uSeq_Overflow_InLow, uSeq_Carry_InLow};
      end
   end

   // Control outputs decode only registered state, so reset clears the
   // strobes immediately and no data input reaches an output.
   always_comb begin
      uSeq_ALU_Selection_Out       = ALU_PASSA;
      uSeq_MUX_A_MIR               = REG_R0;
      uSeq_MUX_B_MIR               = REG_R0;
      uSeq_MUX_C_MIR               = REG_R0;
      uSeq_MUX_A_MIR_Selector      = 1'b0;
      uSeq_MUX_B_MIR_Selector      = 1'b0;
      uSeq_MUX_C_MIR_Selector      = 1'b0;
      uSeq_DataMemory_Selector_Out = 1'b0;
      uSeq_Mem_Rd_Out              = 1'b0;
      uSeq_Mem_Wr_Out              = 1'b0;
      uSeq_Halt_Out                = 1'b0;
      case (state)
         ST_FETCH: begin
            uSeq_Mem_Rd_Out              = 1'b1;
            uSeq_MUX_A_MIR               = REG_PC;
            uSeq_MUX_C_MIR               = REG_IR;
            uSeq_DataMemory_Selector_Out = 1'b1;
         end
         ST_EXEC_ALU: begin
            uSeq_ALU_Selection_Out  = alu_q;
            uSeq_MUX_A_MIR_Selector = 1'b1;
            uSeq_MUX_C_MIR_Selector = 1'b1;
            if (ir13_q) uSeq_MUX_B_MIR          = REG_SIMM;
            else        uSeq_MUX_B_MIR_Selector = 1'b1;
         end
         ST_MEM: begin
            uSeq_ALU_Selection_Out  = ALU_ADD;   // effective address rs1 + rs2/simm13
            uSeq_MUX_A_MIR_Selector = 1'b1;
            if (ir13_q) uSeq_MUX_B_MIR          = REG_SIMM;
            else        uSeq_MUX_B_MIR_Selector = 1'b1;
            if (is_st_q) begin
               uSeq_Mem_Wr_Out = 1'b1;
            end else begin
               uSeq_Mem_Rd_Out              = 1'b1;
               uSeq_DataMemory_Selector_Out = 1'b1;
               uSeq_MUX_C_MIR_Selector      = 1'b1;
            end
         end
         ST_BRANCH: begin
            if (taken_q) begin
               uSeq_ALU_Selection_Out = ALU_ADD;
               uSeq_MUX_A_MIR         = REG_PC;
               uSeq_MUX_B_MIR         = REG_SIMM;
               uSeq_MUX_C_MIR         = REG_PC;
            end
         end
         ST_PC_INC: begin
            uSeq_ALU_Selection_Out = ALU_INC4;
            uSeq_MUX_A_MIR         = REG_PC;
            uSeq_MUX_C_MIR         = REG_PC;
         end
         ST_FAULT, ST_TRAP: uSeq_Halt_Out = 1'b1;
         default: ;
      endcase
   end

   assign uSeq_PSR_Flags_Out = psr;
   assign uSeq_State_Out     = state;

endmodule

// File: tb/tb_useq_controller.sv
// Bench for useq_controller: instruction-level generator fills a stimulus queue
// and an expected-output queue; a driver replays stimulus, a monitor checks outputs.
module tb_useq_controller;
   import useq_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] op = 8'h00;
   logic       ir13 = 1'b0;
   logic       ovf_n = 1'b1, car_n = 1'b1, neg_n = 1'b1, zer_n = 1'b1;
   logic       fw = 1'b0;
   logic       ack = 1'b0;
   logic [3:0] alu_sel;
   logic [5:0] mux_a, mux_b, mux_c;
   logic       sel_a, sel_b, sel_c, dms, mem_rd, mem_wr, halt;
   logic [3:0] psr_o, state_o;

   useq_controller dut (
      .uSeq_CLOCK_50               (clk),
      .uSeq_RESET_InLow            (rst_n),
      .uSeq_Start_In               (start),
      .uSeq_Reg_IR_OP              (op),
      .uSeq_Reg_IR_IR13            (ir13),
      .uSeq_Overflow_InLow         (ovf_n),
      .uSeq_Carry_InLow            (car_n),
      .uSeq_Negative_InLow         (neg_n),
      .uSeq_Zero_InLow             (zer_n),
      .uSeq_ALU_Flags_Write_PCR    (fw),
      .uSeq_Mem_Ack_In             (ack),
      .uSeq_ALU_Selection_Out      (alu_sel),
      .uSeq_MUX_A_MIR              (mux_a),
      .uSeq_MUX_B_MIR              (mux_b),
      .uSeq_MUX_C_MIR              (mux_c),
      .uSeq_MUX_A_MIR_Selector     (sel_a),
      .uSeq_MUX_B_MIR_Selector     (sel_b),
      .uSeq_MUX_C_MIR_Selector     (sel_c),
      .uSeq_DataMemory_Selector_Out(dms),
      .uSeq_Mem_Rd_Out             (mem_rd),
      .uSeq_Mem_Wr_Out             (mem_wr),
      .uSeq_PSR_Flags_Out          (psr_o),
      .uSeq_State_Out              (state_o),
      .uSeq_Halt_Out               (halt)
   );

   initial forever #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] st;
      logic [3:0] alu;
      logic [5:0] a, b, c;
      logic       as, bs, cs, dms, rd, wr, halt;
      logic [3:0] psr;
   } obs_t;

   typedef struct packed {
      logic       start;
      logic [7:0] op;
      logic       ir13;
      logic [3:0] fl_n;   // {N,Z,V,C} active-low
      logic       fw;
      logic       ack;
   } stim_t;

   obs_t  exp_q[$];
   stim_t in_q[$];
   int    checks = 0;
   int    failures = 0;
   int    cyc = 0;
   bit    active = 1'b0;
   logic [3:0] psr_m = 4'h0;     // reference PSR as seen during the cycle being generated
   logic [5:0] alu_ops [6] = '{6'h00, 6'h01, 6'h02, 6'h10, 6'h11, 6'h12};

   function automatic obs_t get_obs();
      obs_t o;
      o.st = state_o; o.alu = alu_sel; o.a = mux_a; o.b = mux_b; o.c = mux_c;
      o.as = sel_a; o.bs = sel_b; o.cs = sel_c; o.dms = dms;
      o.rd = mem_rd; o.wr = mem_wr; o.halt = halt; o.psr = psr_o;
      return o;
   endfunction

   task automatic check_obs(input string name, input obs_t act, input obs_t req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%h required=%h (state %0d, required state %0d)",
                  name, cyc, act, req, act.st, req.st);
      end
   endtask

   // Expected outputs of a quiet state: everything zero, ALU PASSA, current PSR
   function automatic obs_t base(input logic [3:0] st);
      obs_t o;
      o = '0; o.st = st; o.alu = ALU_PASSA; o.psr = psr_m;
      return o;
   endfunction

   function automatic stim_t junk();
      stim_t s;
      s.start = 1'($urandom); s.op = 8'($urandom); s.ir13 = 1'($urandom);
      s.fl_n = 4'($urandom); s.fw = 1'($urandom); s.ack = 1'($urandom);
      return s;
   endfunction

   // ALU table: ADD/AND/OR are 0/2/4, the cc variant adds one
   function automatic logic [3:0] alu_of(input logic [5:0] op3);
      int v;
      v = int'(op3[1:0]) * 2 + int'(op3[4]);
      return 4'(v);
   endfunction

   function automatic int rnd_delay();
      if ($urandom_range(0, 7) == 0) return 14;
      return $urandom_range(0, 3);
   endfunction

   task automatic push(input stim_t s, input obs_t o);
      in_q.push_back(s);
      exp_q.push_back(o);
   endtask

   task automatic gen_idle_start();
      stim_t s;
      s = junk(); s.start = 1'b0; push(s, base(ST_IDLE));
      s = junk(); s.start = 1'b1; push(s, base(ST_IDLE));
   endtask

   task automatic gen_fetch(input int d);
      stim_t s; obs_t o;
      for (int i = 0; i <= d; i++) begin
         o = base(ST_FETCH); o.rd = 1'b1; o.a = REG_PC; o.c = REG_IR; o.dms = 1'b1;
         s = junk(); s.ack = (i == d);
         push(s, o);
      end
   endtask

   task automatic gen_pc_inc();
      obs_t o;
      o = base(ST_PC_INC); o.a = REG_PC; o.c = REG_PC; o.alu = ALU_INC4;
      push(junk(), o);
   endtask

   function automatic obs_t mem_obs(input logic is_st, input logic i13);
      obs_t o;
      o = base(ST_MEM); o.alu = ALU_ADD; o.as = 1'b1;
      if (i13) o.b = REG_SIMM; else o.bs = 1'b1;
      if (is_st) o.wr = 1'b1;
      else begin o.rd = 1'b1; o.dms = 1'b1; o.cs = 1'b1; end
      return o;
   endfunction

   task automatic gen_instr(input logic [7:0] iop, input logic i13, input int fd, input int md,
                            input logic ifw, input logic [3:0] fl_n, output bit stopped);
      stim_t s; obs_t o; logic [5:0] op3; logic [3:0] cond; bit taken;
      stopped = 1'b0; op3 = iop[5:0]; cond = iop[5:2];
      gen_fetch(fd);
      s = junk(); s.op = iop; s.ir13 = i13; push(s, base(ST_DECODE));
      if (iop[7:6] == 2'b10 && (op3 inside {6'h00, 6'h01, 6'h02, 6'h10, 6'h11, 6'h12})) begin
         o = base(ST_EXEC_ALU); o.alu = alu_of(op3); o.as = 1'b1; o.cs = 1'b1;
         if (i13) o.b = REG_SIMM; else o.bs = 1'b1;
         s = junk(); s.fw = ifw; s.fl_n = fl_n; push(s, o);
         if (ifw) psr_m = ~fl_n;
         gen_pc_inc();
      end else if (iop[7:6] == 2'b11 && (op3 == 6'h00 || op3 == 6'h04)) begin
         for (int i = 0; i <= md; i++) begin
            s = junk(); s.ack = (i == md);
            push(s, mem_obs(op3 == 6'h04, i13));
         end
         gen_pc_inc();
      end else if (iop[7:6] == 2'b00) begin
         taken = (cond == 4'h8) || (cond == 4'h1 && psr_m[2]) || (cond == 4'h6 && psr_m[3]) ||
                 (cond == 4'h5 && psr_m[0]) || (cond == 4'h7 && psr_m[1]);
         o = base(ST_BRANCH);
         if (taken) begin o.alu = ALU_ADD; o.a = REG_PC; o.b = REG_SIMM; o.c = REG_PC; end
         push(junk(), o);
         if (!taken) gen_pc_inc();
      end else begin
`ifdef USEQ_TRAP_EN
         for (int i = 0; i < 4; i++) begin
            o = base(ST_TRAP); o.halt = 1'b1; push(junk(), o);
         end
         stopped = 1'b1;
`else
         gen_pc_inc();
`endif
      end
   endtask

   // Driver: applies one stimulus record per cycle, just after the falling edge
   initial forever begin
      stim_t s;
      @(negedge clk);
      if (active) begin
         #1;
         if (in_q.size() > 0) s = in_q.pop_front();
         else begin s = '0; s.fl_n = 4'hF; end
         start = s.start; op = s.op; ir13 = s.ir13;
         {neg_n, zer_n, ovf_n, car_n} = s.fl_n; fw = s.fw; ack = s.ack;
      end
   end

   // Monitor: one expected record per cycle, sampled on the falling edge
   initial forever begin
      obs_t e;
      @(negedge clk);
      cyc++;
      if (active && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_obs("cycle", get_obs(), e);
      end
   end

   task automatic run_seg(input string name);
      @(posedge clk); #2;
      rst_n = 1'b1;
      active = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
      end
      if (exp_q.size() != 0) begin
         checks++; failures++;
         $display("FAIL %s_timeout pending=%0d required=0", name, exp_q.size());
         exp_q.delete(); in_q.delete();
      end
      active = 1'b0;
   endtask

   task automatic reset_and_check(input string name);
      rst_n = 1'b0;
      #1;
      psr_m = 4'h0;
      check_obs(name, get_obs(), base(ST_IDLE));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   bit         stopped;
   int         k;
   logic [7:0] rop;

   initial begin
      #12;
      check_obs("reset_state", get_obs(), base(ST_IDLE));

      // Directed: ADDCC sets Z, BE taken, ADD clears flags, BE not taken,
      // ld accepted on the last allowed cycle, st, BA, illegal opcode.
      gen_idle_start();
      gen_instr(8'h90, 1'b0, 2, 0, 1'b1, 4'b1011, stopped);
      gen_instr(8'h04, 1'b0, 0, 0, 1'b0, 4'hF, stopped);
      gen_instr(8'h80, 1'b1, 1, 0, 1'b1, 4'b1111, stopped);
      gen_instr(8'h04, 1'b0, 0, 0, 1'b0, 4'hF, stopped);
      gen_instr(8'hC0, 1'b0, 14, 14, 1'b0, 4'hF, stopped);
      gen_instr(8'hC4, 1'b1, 0, 0, 1'b0, 4'hF, stopped);
      gen_instr(8'h20, 1'b0, 0, 0, 1'b0, 4'hF, stopped);
      gen_instr(8'hBF, 1'b0, 0, 0, 1'b0, 4'hF, stopped);
      run_seg("directed");
      reset_and_check("reset_after_directed");

      // Randomized instruction stream
      gen_idle_start();
      for (int n = 0; n < 80; n++) begin
`ifdef USEQ_TRAP_EN
         k = $urandom_range(0, 7);
`else
         k = $urandom_range(0, 9);
`endif
         case (k)
            0, 1, 2: rop = {2'b10, alu_ops[$urandom_range(0, 5)]};
            3:       rop = 8'hC0;
            4:       rop = 8'hC4;
            5, 6:    rop = {2'b00, 6'($urandom)};
            7:       rop = {2'b00, 4'h1, 2'($urandom)};
            8:       rop = {2'b01, 6'($urandom)};
            default: rop = {($urandom_range(0, 1) == 1) ? 2'b10 : 2'b11, 6'($urandom) | 6'h08};
         endcase
         gen_instr(rop, 1'($urandom), rnd_delay(), rnd_delay(), 1'($urandom), 4'($urandom), stopped);
         if (stopped) break;
      end
      run_seg("random");
      reset_and_check("reset_after_random");

      // ld never acknowledged: 15 MEM cycles, then FAULT held regardless of inputs
      begin
         stim_t s; obs_t o;
         gen_idle_start();
         gen_fetch(0);
         s = junk(); s.op = 8'hC0; s.ir13 = 1'b0; push(s, base(ST_DECODE));
         for (int i = 0; i < 15; i++) begin
            s = junk(); s.ack = 1'b0; push(s, mem_obs(1'b0, 1'b0));
         end
         for (int i = 0; i < 6; i++) begin
            o = base(ST_FAULT); o.halt = 1'b1; push(junk(), o);
         end
      end
      run_seg("fault");
      reset_and_check("reset_after_fault");

      // Reset while a store is waiting: Mem_Wr must drop without a clock edge
      begin
         stim_t s;
         gen_idle_start();
         gen_fetch(0);
         s = junk(); s.op = 8'hC4; s.ir13 = 1'b1; push(s, base(ST_DECODE));
         for (int i = 0; i < 3; i++) begin
            s = junk(); s.ack = 1'b0; push(s, mem_obs(1'b1, 1'b1));
         end
      end
      run_seg("mid_store");
      #3;
      check_obs("store_before_reset", get_obs(), mem_obs(1'b1, 1'b1));
      reset_and_check("reset_mid_store");

      // Restart after the asynchronous reset
      gen_idle_start();
      for (int n = 0; n < 6; n++) begin
         gen_instr({2'b10, alu_ops[$urandom_range(0, 5)]}, 1'($urandom), rnd_delay(), 0,
                   1'($urandom), 4'($urandom), stopped);
         gen_instr({2'b00, 6'($urandom)}, 1'b0, 0, 0, 1'b0, 4'hF, stopped);
      end
      run_seg("restart");
      reset_and_check("reset_final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
